// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

   localparam int MAX_MASTERS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_t;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Round-robin priority encoder: first requester found searching upward from last+1.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] win,
   output logic          valid
);

   always_comb begin
      int idx;
      win   = '0;
      valid = 1'b0;
      idx   = 0;
      for (int off = 1; off <= N; off++) begin
         idx = (int'(last) + off) % N;
         if (!valid && req[idx]) begin
            valid = 1'b1;
            win   = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter; a grant is held for the whole cyc of the winning master.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts transfers the slave never acknowledges.
//
// state | meaning
// IDLE  | no grant held; next winner is picked from m_cyc_i
// BUSY  | granted master is passed through to the shared bus
// ABORT | watchdog fired; waiting for the granted master to drop cyc
import wb_arb_pkg::*;

module wb_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [32*NUM_MASTERS-1:0] m_adr_i,
   input  logic [32*NUM_MASTERS-1:0] m_dat_i,
   input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
   input  logic [NUM_MASTERS-1:0]    m_we_i,
   input  logic [NUM_MASTERS-1:0]    m_cyc_i,
   input  logic [NUM_MASTERS-1:0]    m_stb_i,
   output logic [31:0]               m_dat_o,
   output logic [NUM_MASTERS-1:0]    m_ack_o,
   output logic [NUM_MASTERS-1:0]    m_err_o,
   output logic [31:0]               s_adr_o,
   output logic [31:0]               s_dat_o,
   output logic [3:0]                s_sel_o,
   output logic                      s_we_o,
   output logic                      s_cyc_o,
   output logic                      s_stb_o,
   input  logic [31:0]               s_dat_i,
   input  logic                      s_ack_i,
   input  logic                      s_err_i,
   output logic [NUM_MASTERS-1:0]    grant_o
);

   localparam int IW = clog2(NUM_MASTERS);

   arb_state_t    state, state_nx;
   logic [IW-1:0] gnt, last, pick_win;
   logic          pick_valid;
   logic          timeout_hit;

   rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
      .req   (m_cyc_i),
      .last  (last),
      .win   (pick_win),
      .valid (pick_valid)
   );

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;

   // Built from the master side so the error path does not loop through s_cyc_o.
   assign timeout_hit = (state == BUSY) && m_cyc_i[gnt] && m_stb_i[gnt] &&
                        !s_ack_i && !s_err_i && (wait_cnt == CW'(TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wait_cnt <= '0;
      else if (state == IDLE || s_ack_i || s_err_i)
         wait_cnt <= '0;
      else if (state == BUSY && m_cyc_i[gnt] && m_stb_i[gnt] && !timeout_hit)
         wait_cnt <= wait_cnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pick_valid) state_nx = BUSY;
         BUSY: begin
            if (!m_cyc_i[gnt])    state_nx = IDLE;
            else if (timeout_hit) state_nx = ABORT;
         end
`ifdef WB_ARB_TIMEOUT_EN
         ABORT:   if (!m_cyc_i[gnt]) state_nx = IDLE;
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         gnt     <= '0;
         last    <= IW'(NUM_MASTERS - 1);
         grant_o <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && pick_valid) begin
            gnt     <= pick_win;
            grant_o <= NUM_MASTERS'(1) << pick_win;
         end else if (state != IDLE && state_nx == IDLE) begin
            last    <= gnt;
            grant_o <= '0;
         end
      end
   end

   always_comb begin
      s_adr_o = m_adr_i[32*gnt +: 32];
      s_dat_o = m_dat_i[32*gnt +: 32];
      s_sel_o = m_sel_i[4*gnt +: 4];
      s_we_o  = m_we_i[gnt];
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      m_ack_o = '0;
      m_err_o = '0;
      if (state == BUSY) begin
         s_cyc_o      = m_cyc_i[gnt];
         s_stb_o      = m_stb_i[gnt];
         m_ack_o[gnt] = s_ack_i;
         m_err_o[gnt] = s_err_i | timeout_hit;
      end
   end

   assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed steps, then random traffic against an ownership model.
module tb_wb_rr_arbiter;

   localparam int N  = 2;
   localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [32*N-1:0] m_adr, m_dat_w;
   logic [4*N-1:0]  m_sel;
   logic [N-1:0]    m_we, m_cyc, m_stb;
   logic [31:0]     m_dat_r;
   logic [N-1:0]    m_ack, m_err, grant;
   logic [31:0]     s_adr, s_dat_w, s_dat_r;
   logic [3:0]      s_sel;
   logic            s_we, s_cyc, s_stb, s_ack, s_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the bus, who owned it last, whether it was aborted,
   // and how many strobed cycles have gone unanswered.
   int owner;
   int last_own;
   int waits;
   bit aborted;

   always #5 clk = ~clk;

   wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst     (rst_n),
      .m_adr_i (m_adr),
      .m_dat_i (m_dat_w),
      .m_sel_i (m_sel),
      .m_we_i  (m_we),
      .m_cyc_i (m_cyc),
      .m_stb_i (m_stb),
      .m_dat_o (m_dat_r),
      .m_ack_o (m_ack),
      .m_err_o (m_err),
      .s_adr_o (s_adr),
      .s_dat_o (s_dat_w),
      .s_sel_o (s_sel),
      .s_we_o  (s_we),
      .s_cyc_o (s_cyc),
      .s_stb_o (s_stb),
      .s_dat_i (s_dat_r),
      .s_ack_i (s_ack),
      .s_err_i (s_err),
      .grant_o (grant)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      owner    = -1;
      last_own = N - 1;
      waits    = 0;
      aborted  = 1'b0;
   endtask

   task automatic check_model();
      logic         busy, ec, es, to_hit;
      logic [N-1:0] eg, ea, ee;
      busy   = (owner >= 0) && !aborted;
      eg     = '0;
      ea     = '0;
      ee     = '0;
      ec     = 1'b0;
      es     = 1'b0;
      to_hit = 1'b0;
      if (owner >= 0) eg[owner] = 1'b1;
      if (busy) begin
         ec         = m_cyc[owner];
         es         = m_stb[owner];
         to_hit     = TO_EN && ec && es && !s_ack && !s_err && (waits == TO);
         ea[owner]  = s_ack;
         ee[owner]  = s_err | to_hit;
      end
      check("grant", 32'(grant), 32'(eg));
      check("s_cyc", 32'(s_cyc), 32'(ec));
      check("s_stb", 32'(s_stb), 32'(es));
      check("m_ack", 32'(m_ack), 32'(ea));
      check("m_err", 32'(m_err), 32'(ee));
      check("m_dat", m_dat_r, s_dat_r);
      if (busy) begin
         check("s_adr", s_adr, m_adr[32*owner +: 32]);
         check("s_dat", s_dat_w, m_dat_w[32*owner +: 32]);
         check("s_sel", 32'(s_sel), 32'(m_sel[4*owner +: 4]));
         check("s_we", 32'(s_we), 32'(m_we[owner]));
      end
   endtask

   task automatic model_edge();
      if (owner < 0) begin
         for (int off = 1; off <= N; off++) begin
            int i;
            i = (last_own + off) % N;
            if (owner < 0 && m_cyc[i]) begin
               owner   = i;
               waits   = 0;
               aborted = 1'b0;
            end
         end
      end else if (!m_cyc[owner]) begin
         last_own = owner;
         owner    = -1;
         aborted  = 1'b0;
      end else if (!aborted) begin
         if (TO_EN && m_stb[owner] && !s_ack && !s_err && waits == TO) aborted = 1'b1;
         else if (s_ack || s_err) waits = 0;
         else if (m_stb[owner]) waits++;
      end
   endtask

   // Called at a falling edge with inputs already set; returns at the next falling edge.
   task automatic tick();
      #1;
      check_model();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input int i, input logic cyc, input logic stb);
      m_cyc[i] = cyc;
      m_stb[i] = stb;
   endtask

   initial begin
      rst_n   = 1'b0;
      m_adr   = {32'h0000_2000, 32'h0000_1000};
      m_dat_w = {32'hBBBB_0001, 32'hAAAA_0000};
      m_sel   = 8'hF3;
      m_we    = 2'b10;
      m_cyc   = '0;
      m_stb   = '0;
      s_dat_r = 32'hDEAD_BEEF;
      s_ack   = 1'b1;
      s_err   = 1'b0;
      model_reset();

      // reset state, with a stray slave ack present
      #3;
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_cyc", 32'(s_cyc), 32'h0);
      check("rst_stb", 32'(s_stb), 32'h0);
      check("rst_ack", 32'(m_ack), 32'h0);
      check("rst_err", 32'(m_err), 32'h0);
      s_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // master 0 alone: 1-cycle arbitration, ack 3 cycles after strobe
      drive(0, 1'b1, 1'b1);
      #1;
      check("lat_pre_cyc", 32'(s_cyc), 32'h0);
      tick();
      #1;
      check("lat_cyc", 32'(s_cyc), 32'h1);
      check("lat_grant", 32'(grant), 32'h1);
      tick();
      tick();
      tick();
      s_ack = 1'b1;
      #1;
      check("rd_ack", 32'(m_ack), 32'h1);
      check("rd_dat", m_dat_r, 32'hDEAD_BEEF);
      tick();
      s_ack = 1'b0;
      drive(0, 1'b0, 1'b0);
      #1;
      check("rd_ack_once", 32'(m_ack), 32'h0);
      tick();
      tick();

      // simultaneous requests after reset: master 0 first, master 1 two cycles after release
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive(0, 1'b1, 1'b1);
      drive(1, 1'b1, 1'b1);
      tick();
      #1;
      check("tie_first", 32'(grant), 32'h1);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      drive(0, 1'b0, 1'b0);
      tick();
      #1;
      check("tie_gap", 32'(grant), 32'h0);
      tick();
      #1;
      check("tie_second", 32'(grant), 32'h2);
      check("tie_adr", s_adr, 32'h0000_2000);

      // master 1 locks the bus with stb low while master 0 waits
      drive(1, 1'b1, 1'b0);
      drive(0, 1'b1, 1'b1);
      for (int c = 0; c < 50; c++) begin
         #1;
         check("lock_grant", 32'(grant), 32'h2);
         check("lock_stb", 32'(s_stb), 32'h0);
         check("lock_ack0", 32'(m_ack[0]), 32'h0);
         tick();
      end
      drive(1, 1'b0, 1'b0);
      tick();
      tick();
      #1;
      check("lock_handover", 32'(grant), 32'h1);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      drive(0, 1'b0, 1'b0);
      tick();
      tick();

      if (TO_EN) begin
         // ack coincides with the watchdog limit: ack wins
         drive(0, 1'b1, 1'b1);
         tick();
         for (int c = 0; c < TO; c++) tick();
         s_ack = 1'b1;
         #1;
         check("to_ack_fwd", 32'(m_ack), 32'h1);
         check("to_ack_noerr", 32'(m_err), 32'h0);
         tick();
         s_ack = 1'b0;
         drive(0, 1'b0, 1'b0);
         tick();
         tick();

         // slave never answers: one-cycle error, bus dropped until cyc falls
         drive(0, 1'b1, 1'b1);
         tick();
         for (int c = 0; c < TO; c++) begin
            #1;
            check("to_wait_noerr", 32'(m_err), 32'h0);
            tick();
         end
         #1;
         check("to_err", 32'(m_err), 32'h1);
         check("to_err_cyc", 32'(s_cyc), 32'h1);
         tick();
         for (int c = 0; c < 5; c++) begin
            #1;
            check("to_abort_cyc", 32'(s_cyc), 32'h0);
            check("to_abort_err", 32'(m_err), 32'h0);
            tick();
         end
         drive(0, 1'b0, 1'b0);
         tick();
         #1;
         check("to_idle", 32'(grant), 32'h0);
         tick();
      end

      // asynchronous reset in the middle of a master-0 transfer
      drive(0, 1'b1, 1'b1);
      tick();
      tick();
      s_ack = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_cyc", 32'(s_cyc), 32'h0);
      check("arst_stb", 32'(s_stb), 32'h0);
      check("arst_grant", 32'(grant), 32'h0);
      check("arst_ack", 32'(m_ack), 32'h0);
      model_reset();
      s_ack = 1'b0;
      drive(0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1'b1, 1'b1);
      drive(1, 1'b1, 1'b1);
      tick();
      #1;
      check("arst_prio", 32'(grant), 32'h1);
      drive(0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0);
      tick();
      tick();

      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(5) == 0) m_cyc[i] = ~m_cyc[i];
            m_stb[i]            = m_cyc[i] & ($urandom_range(3) != 0);
            m_adr[32*i +: 32]   = $urandom();
            m_dat_w[32*i +: 32] = $urandom();
            m_sel[4*i +: 4]     = 4'($urandom_range(15));
            m_we[i]             = 1'($urandom_range(1));
         end
         s_ack   = ($urandom_range(3) == 0);
         s_err   = ($urandom_range(15) == 0);
         s_dat_r = $urandom();
         tick();
      end
      m_cyc = '0;
      m_stb = '0;
      s_ack = 1'b0;
      s_err = 1'b0;
      tick();
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter that shares one slave-side bus port among `NUM_MASTERS` requesters. It sits between the LM32 instruction/data masters (plus future DMA-style masters such as an everloop frame fetcher) and `conbus`, and replaces fixed-priority sharing. A grant is held for the whole `cyc` of a master. An optional watchdog aborts transfers that a slave never acknowledges.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of requesters; legal range 2..4.
- `TIMEOUT`, 255: slave wait-cycle limit before abort; legal range 1..65535; used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `m_adr_i`  in  32*N  master addresses; master k occupies bits [32k+31:32k].
- `m_dat_i`  in  32*N  master write data, same packing as `m_adr_i`.
- `m_sel_i`  in  4*N  master byte selects.
- `m_we_i`  in  N  master write enables.
- `m_cyc_i`  in  N  master cycle requests.
- `m_stb_i`  in  N  master strobes.
- `m_dat_o`  out  32  read data, broadcast to all masters; equals `s_dat_i`.
- `m_ack_o`  out  N  per-master acknowledge.
- `m_err_o`  out  N  per-master error.
- `s_adr_o`  out  32  address to the shared bus.
- `s_dat_o`  out  32  write data to the shared bus.
- `s_sel_o`  out  4  byte selects to the shared bus.
- `s_we_o`  out  1  write enable to the shared bus.
- `s_cyc_o`  out  1  cycle to the shared bus.
- `s_stb_o`  out  1  strobe to the shared bus.
- `s_dat_i`  in  32  read data from the shared bus.
- `s_ack_i`  in  1  acknowledge from the shared bus.
- `s_err_i`  in  1  error from the shared bus.
- `grant_o`  out  N  one-hot registered grant, for debug and LED.

## Operation
- States:
  - IDLE: no grant is held.
  - BUSY: the granted master's signals are passed to the shared bus.
  - ABORT: only present with the macro; a timed-out master is waiting to drop `cyc`.
- IDLE → BUSY:
  - Applies when any `m_cyc_i` is high.
  - The winner is the first requester found searching upward (modulo N) from `last+1`.
  - The winner index is registered into `gnt`, and `grant_o` becomes one-hot.
- In BUSY, the shared-bus outputs `s_adr_o`/`s_dat_o`/`s_sel_o`/`s_we_o`/`s_cyc_o`/`s_stb_o` are combinational copies of the granted master's signals.
- Response routing in BUSY:
  - `m_ack_o[gnt]` = `s_ack_i`.
  - `m_err_o[gnt]` = `s_err_i`.
  - All other `m_ack_o`/`m_err_o` bits are 0.
- Outside BUSY, `s_cyc_o` and `s_stb_o` are 0 and all `m_ack_o`/`m_err_o` bits are 0.
- BUSY → IDLE when `m_cyc_i[gnt]` is low; `last` ← `gnt` and `grant_o` ← 0.
- Requests arriving while a grant is held are ignored.
- A granted master holding `cyc` with `stb` low (bus lock, burst gap) keeps the grant indefinitely.
- Reset:
  - State is IDLE.
  - `last` = N-1, so master 0 has first priority.
  - `grant_o` = 0.
  - All `*_ack_o`/`*_err_o` outputs are 0.
  - `s_cyc_o` and `s_stb_o` are 0.
- Reset asserted mid-transfer drops `s_cyc_o` immediately (asynchronous reset); no ack is delivered.

## Timing
- Arbitration latency is 1 cycle: `cyc` is raised at edge 0 and `s_cyc_o` goes high after edge 1.
- Release-to-next-grant costs 2 cycles:
  - Cycle k: `cyc` low; the state leaves BUSY at edge k+1.
  - At edge k+1 the state is IDLE and the new winner is registered.
  - `s_cyc_o` for the new master goes high after edge k+2.
- The ack path is combinational, adding zero cycles between `s_ack_i` and `m_ack_o`.
- Simultaneous requests are resolved by round-robin order. Example with N=2: after master 0 has held the grant, master 1 wins a tie.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined — watchdog compiled in:
  - Counter width is clog2(TIMEOUT+1).
  - The counter clears on entering BUSY and whenever `s_ack_i` or `s_err_i` is high.
  - It increments each cycle in which `s_cyc_o & s_stb_o` is high and there is no ack/err.
  - When the count equals TIMEOUT, `m_err_o[gnt]` pulses for exactly 1 cycle and the state goes to ABORT.
  - In ABORT, `s_cyc_o`/`s_stb_o` are 0; the state leaves ABORT for IDLE when `m_cyc_i[gnt]` is low.
  - If `s_ack_i` and the limit coincide, the ack wins: it is forwarded and the counter clears.
- Undefined: no counter and no ABORT state; errors come only from `s_err_i`.

## Structure
- Package `wb_arb_pkg`:
  - State enum (IDLE, BUSY, ABORT).
  - Max-master constant (4).
  - Function `clog2`.
- Sub-module `rr_pick`: combinational round-robin priority encoder. Inputs are the request vector and `last`; outputs are the winner index and a valid flag.

## Test plan
- Master 0 alone reads with slave ack 3 cycles after `stb` → `s_cyc_o` is high one cycle after request; `m_ack_o` = 01 for 1 cycle; `m_dat_o` equals `s_dat_i` (0xDEADBEEF).
- Both masters assert `cyc` at the same edge after reset → master 0 is granted first; once it releases, `grant_o` = 10 two cycles later.
- Master 1 holds `cyc` with `stb` low for 50 cycles while master 0 requests → `grant_o` stays 10 throughout; master 0 gets no ack and no `s_stb_o`.
- With the macro and TIMEOUT=8, the slave never acks → `m_err_o[gnt]` pulses 1 cycle after 8 wait cycles; `s_cyc_o` is 0 until the master drops `cyc`, then the arbiter is back in IDLE.
- With the macro and TIMEOUT=8, ack arrives on wait cycle 8 → ack is forwarded and no err is raised.
- Reset pulled low mid-transfer → `s_cyc_o`, `grant_o` and all `m_ack_o` bits are 0 asynchronously; after release, master 0 has first priority.
